// File: rtl/memoria_programa.sv
// Program memory with a byte-stream loader and a registered instruction fetch port.
// Ports: i_clk/i_reset; loader i_load_start/i_load_valid/i_load_byte/o_load_ready;
//        fetch i_PC/i_enable -> o_Instruction (1-cycle latency); status o_loaded/o_words/o_error.
// Latency: one cycle from i_PC to o_Instruction; the loader accepts one byte per cycle while o_load_ready=1.
module memoria_programa #(
    parameter int                NBITS  = 32,
    parameter int                CELDAS = 256,
    parameter logic [NBITS-1:0]  HALT   = 32'hFFFF_FFFF,
    localparam int               ADDRW  = $clog2(CELDAS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NBITS-1:0] i_PC,
    input  logic             i_enable,
    input  logic             i_load_start,
    input  logic             i_load_valid,
    input  logic [7:0]       i_load_byte,
    output logic             o_load_ready,
    output logic [NBITS-1:0] o_Instruction,
    output logic             o_loaded,
    output logic [ADDRW:0]   o_words,
    output logic             o_error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [NBITS-3:0] CELDAS_IDX = (NBITS-2)'(CELDAS);
    localparam logic [ADDRW:0]   LAST_PTR   = (ADDRW+1)'(CELDAS - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [NBITS-9:0] asm_q, asm_d;
    logic [ADDRW:0]   wr_ptr_q, wr_ptr_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic             err_q, err_d;
    logic             we;

    logic [NBITS-1:0] mem_q [CELDAS];

    logic [NBITS-1:0] word;
    logic [NBITS-3:0] pc_word;
    logic             fetch_ok;

    // Incoming byte lands in the low lane; earlier bytes have shifted up,
    // so after four bytes the first one sits in the top byte.
    assign word     = {asm_q, i_load_byte};
    assign pc_word  = i_PC[NBITS-1:2];
    assign fetch_ok = (i_PC[1:0] == 2'b00) && (pc_word < CELDAS_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        instr_d  = instr_q;
        err_d    = err_q;
        we       = 1'b0;

        if (i_load_start) begin
            // Restart from any state; a byte presented in the same cycle is dropped.
            state_d  = LOAD;
            cnt_d    = 2'd0;
            wr_ptr_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (i_load_valid) begin
                        asm_d = word[NBITS-9:0];
                        if (cnt_q == 2'd3) begin
                            cnt_d    = 2'd0;
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            if (word == HALT) begin
                                state_d = RUN;
                            end else if (wr_ptr_q == LAST_PTR) begin
                                // Memory full without an end marker.
                                err_d   = 1'b1;
                                state_d = RUN;
                            end
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                RUN: begin
                    if (i_enable) begin
                        if (fetch_ok) begin
                            instr_d = mem_q[pc_word[ADDRW-1:0]];
                        end else begin
                            instr_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Instruction output reads as NOP whenever the next state is not RUN,
        // and RUN starts from NOP until the first enabled fetch.
        if (state_d != RUN) begin
            instr_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            instr_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset; reset only blocks a write in flight.
    always_ff @(posedge i_clk) begin
        if (we && !i_reset) begin
            mem_q[wr_ptr_q[ADDRW-1:0]] <= word;
        end
    end

    assign o_load_ready  = (state_q == LOAD);
    assign o_loaded      = (state_q == RUN);
    assign o_words       = wr_ptr_q;
    assign o_Instruction = instr_q;
    assign o_error       = err_q;

endmodule

// File: tb/tb_memoria_programa.sv
module tb_memoria_programa;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance (256 words)
    logic        rst;
    logic [31:0] pc;
    logic        en, ld_start, ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready, loaded, err;
    logic [31:0] instr;
    logic [8:0]  words;

    // Small instance (4 words) for overflow
    logic [31:0] pc4;
    logic        en4, ld4_start, ld4_valid;
    logic [7:0]  ld4_byte;
    logic        ld4_ready, loaded4, err4;
    logic [31:0] instr4;
    logic [2:0]  words4;

    memoria_programa dut (
        .i_clk(clk), .i_reset(rst), .i_PC(pc), .i_enable(en),
        .i_load_start(ld_start), .i_load_valid(ld_valid), .i_load_byte(ld_byte),
        .o_load_ready(ld_ready), .o_Instruction(instr), .o_loaded(loaded),
        .o_words(words), .o_error(err)
    );

    memoria_programa #(.CELDAS(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_PC(pc4), .i_enable(en4),
        .i_load_start(ld4_start), .i_load_valid(ld4_valid), .i_load_byte(ld4_byte),
        .o_load_ready(ld4_ready), .o_Instruction(instr4), .o_loaded(loaded4),
        .o_words(words4), .o_error(err4)
    );

    // Reference model: word-addressed program image plus expected status.
    logic [31:0] mdl_mem [256];
    logic [31:0] wq [$];
    int          exp_words;
    logic [31:0] exp_instr;
    logic        exp_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                tick();
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    // Load the words in wq (big-endian bytes) and update the model.
    task automatic run_load(input bit gaps);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("load_ready_after_start", {31'd0, ld_ready}, 32'd1);
        exp_words = 0;
        foreach (wq[i]) begin
            logic [31:0] w;
            w = wq[i];
            for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gaps);
            mdl_mem[i] = w;
            exp_words  = i + 1;
            if (w == HALT) break;
        end
        exp_instr = 32'd0;
        chk("loaded_after_halt", {31'd0, loaded}, 32'd1);
        chk("words_after_load", {23'd0, words}, exp_words);
        chk("instr_nop_before_fetch", instr, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic e);
        pc = a;
        en = e;
        if (e) begin
            if (a[1:0] != 2'b00 || (a >> 2) >= 256) begin
                exp_instr = 32'd0;
                exp_err   = 1'b1;
            end else begin
                exp_instr = mdl_mem[a >> 2];
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = '0; en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
        pc4 = '0; en4 = 1'b0; ld4_start = 1'b0; ld4_valid = 1'b0; ld4_byte = '0;
        exp_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_load_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_words", {23'd0, words}, 32'd0);
        chk("rst_error", {31'd0, err}, 32'd0);

        // Basic two-word program with a fetch
        wq = '{32'h8C62_0002, HALT};
        run_load(1'b0);
        chk("halt_load_ready_low", {31'd0, ld_ready}, 32'd0);
        fetch(32'd0, 1'b1);
        chk("fetch_pc0", instr, 32'h8C62_0002);

        // Stall holds the output
        fetch(32'd4, 1'b1);
        chk("fetch_pc4", instr, HALT);
        fetch(32'd0, 1'b0);
        chk("stall_hold_1", instr, HALT);
        tick();
        chk("stall_hold_2", instr, HALT);

        // Misaligned fetch
        chk("error_clear_before_fault", {31'd0, err}, 32'd0);
        fetch(32'd6, 1'b1);
        chk("misaligned_nop", instr, 32'd0);
        chk("misaligned_error", {31'd0, err}, 32'd1);

        // Random program with random fetches
        rst = 1'b1; tick(); rst = 1'b0;
        exp_err = 1'b0;
        chk("rst_clears_error", {31'd0, err}, 32'd0);
        begin
            int nw = $urandom_range(3, 12);
            wq = {};
            for (int i = 0; i < nw; i++) begin
                logic [31:0] w = $urandom;
                if (w == HALT) w = 32'd0;
                wq.push_back(w);
            end
            wq.push_back(HALT);
            run_load(1'b1);
            for (int k = 0; k < 40; k++) begin
                int r = $urandom_range(0, 9);
                logic [31:0] a;
                if (r == 0)      a = 32'($urandom_range(0, nw) * 4 + $urandom_range(1, 3));
                else if (r == 1) a = 32'(1024 + 4 * $urandom_range(0, 1000));
                else             a = 32'($urandom_range(0, nw) * 4);
                fetch(a, $urandom_range(0, 3) != 0);
                chk("rand_fetch_instr", instr, exp_instr);
                chk("rand_fetch_error", {31'd0, err}, {31'd0, exp_err});
            end
        end

        // Reset in the middle of a load discards the partial word
        rst = 1'b1; tick(); rst = 1'b0;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midload_rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("midload_rst_loaded", {31'd0, loaded}, 32'd0);
        chk("midload_rst_words", {23'd0, words}, 32'd0);
        tick();
        chk("idle_stays_idle", {31'd0, ld_ready}, 32'd0);
        wq = '{32'h1122_3344, HALT};
        run_load(1'b0);
        fetch(32'd0, 1'b1);
        chk("reload_from_zero", instr, 32'h1122_3344);

        // Bytes outside LOAD are ignored
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        chk("valid_in_run_words", {23'd0, words}, 32'd2);
        chk("valid_in_run_loaded", {31'd0, loaded}, 32'd1);

        // Restart in RUN with a byte in the start cycle
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h55;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        chk("restart_ready", {31'd0, ld_ready}, 32'd1);
        chk("restart_instr_nop", instr, 32'd0);
        chk("restart_words", {23'd0, words}, 32'd0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        chk("reload_instr_nop", instr, 32'd0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'hFF, 1'b0);
        chk("restart_loaded", {31'd0, loaded}, 32'd1);
        mdl_mem[0] = 32'hDEAD_BEEF;
        fetch(32'd0, 1'b1);
        chk("restart_byte_dropped", instr, 32'hDEAD_BEEF);

        // Overflow on the 4-word instance
        begin
            logic [31:0] m4 [4];
            ld4_start = 1'b1; tick(); ld4_start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m4[i] = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] b = 8'($urandom_range(0, 254));
                    m4[i] = {m4[i][23:0], b};
                    ld4_valid = 1'b1; ld4_byte = b;
                    tick();
                    ld4_valid = 1'b0;
                end
            end
            chk("ovf_words", {29'd0, words4}, 32'd4);
            chk("ovf_error", {31'd0, err4}, 32'd1);
            chk("ovf_loaded", {31'd0, loaded4}, 32'd1);
            chk("ovf_ready_low", {31'd0, ld4_ready}, 32'd0);
            ld4_valid = 1'b1; ld4_byte = 8'h01; tick(); ld4_valid = 1'b0;
            chk("ovf_17th_ignored", {29'd0, words4}, 32'd4);
            pc4 = 32'd12; en4 = 1'b1; tick();
            chk("ovf_last_cell", instr4, m4[3]);
            pc4 = 32'd0; tick();
            chk("ovf_first_cell", instr4, m4[0]);
            pc4 = 32'd16; tick();
            chk("ovf_out_of_range_nop", instr4, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
